// File: rtl/clock_set_pkg.sv
// Shared encodings and widths for the time-of-day / alarm set controller.
package clock_set_pkg;

  localparam int HW = 5;
  localparam int MW = 6;

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    SET_TIME  = 3'd1,
    SET_ALARM = 3'd2
  } mode_e;

  localparam logic FIELD_H = 1'b0;
  localparam logic FIELD_M = 1'b1;

  // Value a modulo-(max+1) counter takes after one increment.
  function automatic logic [MW-1:0] wrap_next(input logic [MW-1:0] v, input logic [MW-1:0] max);
    return (v == max) ? '0 : v + 1'b1;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) counter with synchronous clear; carry flags the wrap increment.
module wrap_counter #(
  parameter int WIDTH = 6,
  parameter int MAX   = 59
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] value,
  output logic             carry
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  assign carry = inc & (value == MAX_V);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (inc) begin
      value <= carry ? '0 : value + 1'b1;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-of-day and alarm registers with the set-mode FSM that edits them,
// plus the alarm-ring trigger/timeout logic.
module clock_set_ctrl
  import clock_set_pkg::*;
#(
  parameter int HOUR_MAX  = 23,
  parameter int MIN_MAX   = 59,
  parameter int RING_SECS = 60
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          tick_1hz,
  input  logic          semnal_setare,
  input  logic          semnal_setare_a,
  input  logic          semnal_stop,
  input  logic          semnal_b1,
  input  logic          semnal_b2,
  output logic [HW-1:0] hours,
  output logic [MW-1:0] minutes,
  output logic [MW-1:0] seconds,
  output logic [HW-1:0] al_hours,
  output logic [MW-1:0] al_minutes,
  output logic [2:0]    mode,
  output logic          edit_field,
  output logic          alarm_ring
);

  localparam logic [MW-1:0] MIN_MAX_V  = MW'(MIN_MAX);
  localparam logic [MW-1:0] HOUR_MAX_V = MW'(HOUR_MAX);

  logic b1_q, b2_q, setare_q, setare_a_q;
  logic b1_rise, b2_rise, setare_rise, setare_a_rise, setare_fall, setare_a_fall;
  mode_e state_q, state_d;
  logic field_q, field_d;
  logic ring_q, ring_d;
  logic [5:0] ring_cnt_q, ring_cnt_d;
  logic in_run, in_set_time, in_set_alarm;
  logic tick_time, exit_set_time;
  logic edit_h, edit_m, al_edit_h, al_edit_m;
  logic sec_carry, min_carry;
  logic unused_hr_carry, unused_al_min_carry, unused_al_hr_carry;
  logic [MW-1:0] next_min, next_hr;
  logic trigger, clear_ring;

  // Buttons arrive as levels; only the first cycle of each high level acts.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      b1_q       <= 1'b0;
      b2_q       <= 1'b0;
      setare_q   <= 1'b0;
      setare_a_q <= 1'b0;
    end else begin
      b1_q       <= semnal_b1;
      b2_q       <= semnal_b2;
      setare_q   <= semnal_setare;
      setare_a_q <= semnal_setare_a;
    end
  end

  assign b1_rise       = semnal_b1 & ~b1_q;
  assign b2_rise       = semnal_b2 & ~b2_q;
  assign setare_rise   = semnal_setare & ~setare_q;
  assign setare_a_rise = semnal_setare_a & ~setare_a_q;
  assign setare_fall   = setare_q & ~semnal_setare;
  assign setare_a_fall = setare_a_q & ~semnal_setare_a;

  assign in_run       = (state_q == RUN);
  assign in_set_time  = (state_q == SET_TIME);
  assign in_set_alarm = (state_q == SET_ALARM);

  assign tick_time     = tick_1hz & ~in_set_time;
  assign exit_set_time = in_set_time & (semnal_stop | setare_fall);

  assign edit_h    = in_set_time & b1_rise & (field_q == FIELD_H);
  assign edit_m    = in_set_time & b1_rise & (field_q == FIELD_M);
  assign al_edit_h = in_set_alarm & b1_rise & (field_q == FIELD_H);
  assign al_edit_m = in_set_alarm & b1_rise & (field_q == FIELD_M);

  wrap_counter #(.WIDTH(MW), .MAX(MIN_MAX)) u_sec (
    .clock(clock), .reset(reset), .inc(tick_time), .clear(exit_set_time),
    .value(seconds), .carry(sec_carry)
  );

  // An edit can never cascade: sec_carry is zero whenever editing is possible.
  wrap_counter #(.WIDTH(MW), .MAX(MIN_MAX)) u_min (
    .clock(clock), .reset(reset), .inc(sec_carry | edit_m), .clear(1'b0),
    .value(minutes), .carry(min_carry)
  );

  wrap_counter #(.WIDTH(HW), .MAX(HOUR_MAX)) u_hour (
    .clock(clock), .reset(reset), .inc((min_carry & sec_carry) | edit_h), .clear(1'b0),
    .value(hours), .carry(unused_hr_carry)
  );

  wrap_counter #(.WIDTH(MW), .MAX(MIN_MAX)) u_al_min (
    .clock(clock), .reset(reset), .inc(al_edit_m), .clear(1'b0),
    .value(al_minutes), .carry(unused_al_min_carry)
  );

  wrap_counter #(.WIDTH(HW), .MAX(HOUR_MAX)) u_al_hour (
    .clock(clock), .reset(reset), .inc(al_edit_h), .clear(1'b0),
    .value(al_hours), .carry(unused_al_hr_carry)
  );

  // Trigger compares the post-tick time, so it fires on the edge that shows hh:mm:00.
  assign next_min = wrap_next(minutes, MIN_MAX_V);
  assign next_hr  = (minutes == MIN_MAX_V) ? wrap_next({1'b0, hours}, HOUR_MAX_V) : {1'b0, hours};
  assign trigger  = sec_carry & (next_min == al_minutes) & (next_hr == {1'b0, al_hours});
  assign clear_ring = b1_rise | b2_rise | semnal_stop | (in_run & setare_rise);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      field_q    <= FIELD_H;
      ring_q     <= 1'b0;
      ring_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      field_q    <= field_d;
      ring_q     <= ring_d;
      ring_cnt_q <= ring_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    field_d    = field_q;
    ring_d     = ring_q;
    ring_cnt_d = ring_cnt_q;
    case (state_q)
      RUN: begin
        if (setare_rise) begin
          state_d = SET_TIME;
          field_d = FIELD_H;
        end else if (setare_a_rise) begin
          state_d = SET_ALARM;
          field_d = FIELD_H;
        end
      end
      SET_TIME: begin
        if (b2_rise) field_d = ~field_q;
        if (semnal_stop || setare_fall) state_d = RUN;
      end
      SET_ALARM: begin
        if (b2_rise) field_d = ~field_q;
        if (semnal_stop || setare_a_fall) state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    if (clear_ring) begin
      ring_d = 1'b0;
    end else if (trigger) begin
      ring_d     = 1'b1;
      ring_cnt_d = 6'(RING_SECS);
    end else if (tick_1hz && ring_q) begin
      ring_cnt_d = ring_cnt_q - 6'd1;
      if (ring_cnt_q == 6'd1) ring_d = 1'b0;
    end
  end

  assign mode       = state_q;
  assign edit_field = field_q;
  assign alarm_ring = ring_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: vector table, directed multi-cycle sequences and
// random stimulus, all checked against a seconds-of-day reference model.
module tb_clock_set_ctrl;

  localparam int RING = 60;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic tick_1hz = 1'b0, semnal_setare = 1'b0, semnal_setare_a = 1'b0;
  logic semnal_stop = 1'b0, semnal_b1 = 1'b0, semnal_b2 = 1'b0;
  logic [4:0] hours, al_hours;
  logic [5:0] minutes, seconds, al_minutes;
  logic [2:0] mode;
  logic edit_field, alarm_ring;

  int vectors = 0;
  int miscompares = 0;

  clock_set_ctrl #(.HOUR_MAX(23), .MIN_MAX(59), .RING_SECS(RING)) dut (
    .clock(clock), .reset(reset), .tick_1hz(tick_1hz),
    .semnal_setare(semnal_setare), .semnal_setare_a(semnal_setare_a),
    .semnal_stop(semnal_stop), .semnal_b1(semnal_b1), .semnal_b2(semnal_b2),
    .hours(hours), .minutes(minutes), .seconds(seconds),
    .al_hours(al_hours), .al_minutes(al_minutes), .mode(mode),
    .edit_field(edit_field), .alarm_ring(alarm_ring)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, got timeout required finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // Time kept as seconds-of-day, alarm as minute-of-day; modes 0=run 1=set time 2=set alarm.
  int m_t, m_al, m_mode, m_field, m_left;
  bit m_ring;
  bit p_b1, p_b2, p_set, p_seta;

  function automatic void model_reset();
    m_t = 0; m_al = 0; m_mode = 0; m_field = 0; m_left = 0; m_ring = 0;
    p_b1 = 0; p_b2 = 0; p_set = 0; p_seta = 0;
  endfunction

  function automatic void model_step(input bit tk, input bit st, input bit sta,
                                     input bit sp, input bit b1, input bit b2);
    bit b1r, b2r, str, stf, star, staf, trig, clr;
    int h, m;
    b1r = b1 & ~p_b1;   b2r = b2 & ~p_b2;
    str = st & ~p_set;  stf = ~st & p_set;
    star = sta & ~p_seta; staf = ~sta & p_seta;
    trig = 0;
    clr = b1r | b2r | sp;
    if (tk && m_mode != 1) begin
      m_t = (m_t + 1) % 86400;
      trig = (m_t % 60 == 0) && (m_t / 60 == m_al);
    end
    case (m_mode)
      0: begin
        if (str) begin m_mode = 1; m_field = 0; clr = 1; end
        else if (star) begin m_mode = 2; m_field = 0; end
      end
      1: begin
        h = m_t / 3600; m = (m_t / 60) % 60;
        if (b1r) begin if (m_field == 0) h = (h + 1) % 24; else m = (m + 1) % 60; end
        if (b2r) m_field = 1 - m_field;
        m_t = h * 3600 + m * 60 + ((sp || stf) ? 0 : m_t % 60);
        if (sp || stf) m_mode = 0;
      end
      default: begin
        h = m_al / 60; m = m_al % 60;
        if (b1r) begin if (m_field == 0) h = (h + 1) % 24; else m = (m + 1) % 60; end
        if (b2r) m_field = 1 - m_field;
        m_al = h * 60 + m;
        if (sp || staf) m_mode = 0;
      end
    endcase
    if (clr) m_ring = 0;
    else if (trig) begin m_ring = 1; m_left = RING; end
    else if (tk && m_ring) begin
      m_left--;
      if (m_left == 0) m_ring = 0;
    end
    p_b1 = b1; p_b2 = b2; p_set = st; p_seta = sta;
  endfunction

  function automatic logic [32:0] model_vec();
    return {5'(m_t / 3600), 6'((m_t / 60) % 60), 6'(m_t % 60), 5'(m_al / 60), 6'(m_al % 60),
            3'(m_mode), 1'(m_field), m_ring};
  endfunction

  function automatic logic [32:0] dut_vec();
    return {hours, minutes, seconds, al_hours, al_minutes, mode, edit_field, alarm_ring};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clock);
    model_step(tick_1hz, semnal_setare, semnal_setare_a, semnal_stop, semnal_b1, semnal_b2);
    @(negedge clock);
    check("model", dut_vec(), model_vec());
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1hz = 1'b1; cyc();
      tick_1hz = 1'b0; cyc();
    end
  endtask

  task automatic press_b1(input int n);
    for (int i = 0; i < n; i++) begin
      semnal_b1 = 1'b1; cyc();
      semnal_b1 = 1'b0; cyc();
    end
  endtask

  task automatic press_b2(input int n);
    for (int i = 0; i < n; i++) begin
      semnal_b2 = 1'b1; cyc();
      semnal_b2 = 1'b0; cyc();
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    {tick_1hz, semnal_setare, semnal_setare_a, semnal_stop, semnal_b1, semnal_b2} = '0;
    model_reset();
    repeat (2) @(negedge clock);
    check("reset", dut_vec(), 33'd0);
    reset = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit tk, st, sta, sp, b1, b2;
    int h, m, s, ah, am, md, f, rg;
  } vec_t;

  vec_t tbl[23];

  initial begin
    tbl[0]  = '{1,0,0,0,0,0, 0,0,1, 0,0, 0,0,0};
    tbl[1]  = '{0,0,0,0,0,0, 0,0,1, 0,0, 0,0,0};
    tbl[2]  = '{0,1,0,0,0,0, 0,0,1, 0,0, 1,0,0};
    tbl[3]  = '{0,1,0,0,1,0, 1,0,1, 0,0, 1,0,0};
    tbl[4]  = '{0,1,0,0,1,0, 1,0,1, 0,0, 1,0,0};
    tbl[5]  = '{0,1,0,0,0,0, 1,0,1, 0,0, 1,0,0};
    tbl[6]  = '{0,1,0,0,0,1, 1,0,1, 0,0, 1,1,0};
    tbl[7]  = '{0,1,0,0,1,0, 1,1,1, 0,0, 1,1,0};
    tbl[8]  = '{0,1,0,0,1,1, 1,1,1, 0,0, 1,0,0};
    tbl[9]  = '{1,1,0,0,0,0, 1,1,1, 0,0, 1,0,0};
    tbl[10] = '{0,1,0,0,1,1, 2,1,1, 0,0, 1,1,0};
    tbl[11] = '{0,1,0,0,0,0, 2,1,1, 0,0, 1,1,0};
    tbl[12] = '{0,0,0,0,0,0, 2,1,0, 0,0, 0,1,0};
    tbl[13] = '{0,0,1,0,0,0, 2,1,0, 0,0, 2,0,0};
    tbl[14] = '{1,0,1,0,0,0, 2,1,1, 0,0, 2,0,0};
    tbl[15] = '{0,0,1,0,1,0, 2,1,1, 1,0, 2,0,0};
    tbl[16] = '{0,0,1,0,0,1, 2,1,1, 1,0, 2,1,0};
    tbl[17] = '{0,0,1,0,1,1, 2,1,1, 1,1, 2,1,0};
    tbl[18] = '{0,0,0,0,0,0, 2,1,1, 1,1, 0,1,0};
    tbl[19] = '{0,0,0,1,0,0, 2,1,1, 1,1, 0,1,0};
    tbl[20] = '{0,1,1,0,0,0, 2,1,1, 1,1, 1,0,0};
    tbl[21] = '{0,1,1,1,0,0, 2,1,0, 1,1, 0,0,0};
    tbl[22] = '{0,0,0,0,0,0, 2,1,0, 1,1, 0,0,0};

    // ---- reset + table ----
    @(negedge clock);
    do_reset();
    foreach (tbl[i]) begin
      {tick_1hz, semnal_setare, semnal_setare_a, semnal_stop, semnal_b1, semnal_b2} =
        {tbl[i].tk, tbl[i].st, tbl[i].sta, tbl[i].sp, tbl[i].b1, tbl[i].b2};
      cyc();
      check($sformatf("table[%0d]", i), dut_vec(),
            {5'(tbl[i].h), 6'(tbl[i].m), 6'(tbl[i].s), 5'(tbl[i].ah), 6'(tbl[i].am),
             3'(tbl[i].md), 1'(tbl[i].f), 1'(tbl[i].rg)});
    end

    // ---- one hour of ticks, then midnight wrap ----
    do_reset();
    ticks(3600);
    check("run_3600", {hours, minutes, seconds}, {5'd1, 6'd0, 6'd0});
    semnal_setare = 1'b1; cyc();
    press_b1(22); press_b2(1); press_b1(59);
    semnal_setare = 1'b0; cyc();
    ticks(59);
    check("pre_midnight", {hours, minutes, seconds}, {5'd23, 6'd59, 6'd59});
    ticks(1);
    check("midnight_wrap", {hours, minutes, seconds}, {5'd0, 6'd0, 6'd0});
    check("midnight_alarm", alarm_ring, 1);
    press_b2(1);
    check("b2_cancel", alarm_ring, 0);

    // ---- long b1 hold counts once; field edit; stop exit ----
    ticks(5);
    semnal_setare = 1'b1; cyc();
    semnal_b1 = 1'b1; repeat (50) cyc();
    semnal_b1 = 1'b0; cyc();
    press_b1(2);
    check("hold_b1", hours, 3);
    press_b2(1); press_b1(1);
    check("edit_minute", minutes, 1);
    ticks(10);
    check("frozen", seconds, 5);
    semnal_stop = 1'b1; cyc(); semnal_stop = 1'b0;
    check("stop_exit", {mode, seconds}, {3'd0, 6'd0});
    semnal_setare = 1'b0; cyc();

    // ---- alarm set mode keeps time running ----
    semnal_setare_a = 1'b1; cyc();
    press_b2(1); press_b1(2);
    ticks(10);
    check("alarm_mode_ticks", {minutes, seconds}, {6'd1, 6'd10});
    check("alarm_edit", {al_hours, al_minutes}, {5'd0, 6'd2});
    semnal_setare_a = 1'b0; cyc();

    // ---- alarm 00:02 trigger, cancel, no retrigger ----
    semnal_setare = 1'b1; cyc();
    press_b1(21);
    semnal_setare = 1'b0; cyc();
    ticks(59);
    check("pre_alarm", {alarm_ring, hours, minutes, seconds}, {1'b0, 5'd0, 6'd1, 6'd59});
    tick_1hz = 1'b1; cyc(); tick_1hz = 1'b0;
    check("alarm_trigger", {alarm_ring, minutes, seconds}, {1'b1, 6'd2, 6'd0});
    semnal_b1 = 1'b1; cyc(); semnal_b1 = 1'b0;
    check("b1_cancel", alarm_ring, 0);
    cyc();
    ticks(59);
    check("no_retrigger", {alarm_ring, minutes, seconds}, {1'b0, 6'd2, 6'd59});

    // ---- uncancelled ring times out after RING ticks ----
    semnal_setare_a = 1'b1; cyc();
    press_b2(1); press_b1(2);
    semnal_setare_a = 1'b0; cyc();
    ticks(61);
    check("ring_start", {alarm_ring, minutes, seconds}, {1'b1, 6'd4, 6'd0});
    ticks(RING - 1);
    check("ring_hold", alarm_ring, 1);
    ticks(1);
    check("ring_timeout", alarm_ring, 0);

    // ---- trigger coinciding with b2 rise: clear wins ----
    semnal_setare_a = 1'b1; cyc();
    press_b2(1); press_b1(2);
    semnal_setare_a = 1'b0; cyc();
    ticks(59);
    tick_1hz = 1'b1; semnal_b2 = 1'b1; cyc();
    tick_1hz = 1'b0; semnal_b2 = 1'b0;
    check("trig_vs_b2", {alarm_ring, minutes, seconds}, {1'b0, 6'd6, 6'd0});
    cyc();

    // ---- asynchronous reset in the middle of an alarm edit ----
    semnal_setare_a = 1'b1; cyc();
    press_b1(7);
    check("al_hours_set", al_hours, 7);
    #2 reset = 1'b0;
    #1 check("async_reset", dut_vec(), 33'd0);
    model_reset();
    semnal_setare_a = 1'b0;
    @(negedge clock);
    reset = 1'b1;

    // ---- random stimulus against the model ----
    for (int i = 0; i < 3000; i++) begin
      tick_1hz = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 29) == 0) semnal_setare = ~semnal_setare;
      if ($urandom_range(0, 29) == 0) semnal_setare_a = ~semnal_setare_a;
      semnal_stop = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) semnal_b1 = ~semnal_b1;
      if ($urandom_range(0, 5) == 0) semnal_b2 = ~semnal_b2;
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
